port_ctrl: RTL and testbench
============================

PORT_CTRL -- requirements
Module: port_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, cycles without grant before the current packet is dropped.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 fifo_empty  input  1  upstream first-word-fall-through FIFO empty.
REQ-005 fifo_rdata  input  DATA_WIDTH  FIFO head word, valid when fifo_empty=0.
REQ-006 fifo_rd_en  output  1  pop FIFO head this cycle (combinational).
REQ-007 arb_req  output  1  request to switch arbiter for current beat.
REQ-008 arb_dst  output  ADDR_WIDTH  one-hot/multicast destination mask of current packet.
REQ-009 arb_grant  input  1  this port's grant from arbiter, valid same cycle as arb_req.
REQ-010 tx_valid  output  1  registered beat valid toward crossbar.
REQ-011 tx_data  output  DATA_WIDTH  registered beat data.
REQ-012 tx_eop  output  1  registered last-beat marker, qualified by tx_valid.
REQ-013 busy  output  1  FSM not in IDLE.
REQ-014 drop_cnt  output  8  saturating count of dropped packets.

Function
REQ-015 Packet = one header word then LEN payload words; header[ADDR_WIDTH-1:0]=dst mask, header[11:8]=LEN (0..15).
REQ-016 FSM states IDLE, XFER, DROP; one-hot or binary encoding free.
REQ-017 IDLE with fifo_empty=0: pop header (fifo_rd_en=1), latch dst and LEN into remaining counter.
REQ-018 IDLE header with LEN=0 or dst=0: count drop, stay IDLE, no arb_req, no tx.
REQ-019 IDLE valid header: next state XFER, wait counter cleared.
REQ-020 XFER: arb_req = ~fifo_empty; arb_dst = latched dst whenever busy, else 0.
REQ-021 XFER with arb_req & arb_grant: fifo_rd_en=1 same cycle; next cycle tx_valid=1, tx_data=popped word, remaining decremented.
REQ-022 Grant-to-tx_valid latency exactly 1 cycle, aligned with arbiter's registered mux select.
REQ-023 Each payload beat requires its own grant; arb_grant without arb_req ignored.
REQ-024 tx_eop=1 with beat where remaining was 1; FSM returns to IDLE same edge; header of next packet not popped before next cycle.
REQ-025 FIFO empty mid-packet: arb_req=0, tx_valid=0, state held, wait counter held.
REQ-026 Wait counter increments each XFER cycle with arb_req=1 and arb_grant=0; clears on grant.
REQ-027 Wait counter reaching TIMEOUT_CYCLES-1 without grant that cycle: next state DROP, drop_cnt incremented.
REQ-028 DROP: fifo_rd_en = ~fifo_empty, remaining decremented per pop, arb_req=0, tx_valid=0; exit to IDLE after last pop.
REQ-029 Packet partially sent then timed out: already-sent beats stand; no tx_eop issued for that packet.
REQ-030 drop_cnt saturates at 255, never wraps.
REQ-031 tx_valid/tx_eop low in every cycle not following a granted pop.

Reset
REQ-032 rst_n low: state IDLE, remaining, wait counter, drop_cnt, tx_valid, tx_data, tx_eop all 0 immediately.
REQ-033 Reset mid-packet abandons packet without drop count; upstream FIFO shares rst_n and is flushed with it.
REQ-034 fifo_rd_en and arb_req 0 while rst_n low.

Structure
REQ-035 DATA_WIDTH, ADDR_WIDTH, NUM_PORTS, header field positions and FSM state enum live in packet_pkg.
REQ-036 No sub-module; one port_ctrl instanced per input port beside the arbiter.

Verification
REQ-037 Header dst=4'b0100 LEN=3, grant every cycle -> 3 beats on consecutive cycles, each 1 cycle after grant, tx_eop on third.
REQ-038 Header LEN=2, grant alternating 0/1 -> 2 beats, tx_valid only the cycle after each grant, busy until eop.
REQ-039 Header dst=0 LEN=4 -> header popped, drop_cnt 0->1, no arb_req, no tx_valid; payload then parsed as next header (documented).
REQ-040 TIMEOUT_CYCLES=8, LEN=5, grant never -> after 8 requesting cycles DROP pops 5 words, drop_cnt+1, back to IDLE, no tx_valid.
REQ-041 FIFO empties after beat 1 of LEN=3 for 10 cycles with grant=0 -> no timeout, resumes, eop on beat 3.
REQ-042 rst_n asserted mid-XFER -> all outputs 0 same cycle, IDLE after release, drop_cnt=0.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared packet format and port-controller FSM encoding for the switch ingress path.
// Header: dst mask in the low ADDR_WIDTH bits, payload length in bits [11:8].
package packet_pkg;

  localparam int NUM_PORTS   = 4;
  localparam int DATA_WIDTH  = 16;
  localparam int ADDR_WIDTH  = NUM_PORTS;
  localparam int LEN_WIDTH   = 4;
  localparam int HDR_DST_LSB = 0;
  localparam int HDR_LEN_LSB = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_XFER = 2'd1;
  localparam state_t ST_DROP = 2'd2;

  typedef struct packed {
    logic [LEN_WIDTH-1:0]  len;
    logic [ADDR_WIDTH-1:0] dst;
  } hdr_t;

  function automatic hdr_t parse_hdr(input logic [DATA_WIDTH-1:0] word);
    hdr_t h;
    h.dst = word[HDR_DST_LSB +: ADDR_WIDTH];
    h.len = word[HDR_LEN_LSB +: LEN_WIDTH];
    return h;
  endfunction

endpackage

// File: rtl/port_ctrl.sv
// Ingress port controller: pops packets from an FWFT FIFO, requests the switch
// arbiter beat by beat, and discards packets that are malformed or starve for grant.
module port_ctrl
  import packet_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  arb_req,
  output logic [ADDR_WIDTH-1:0] arb_dst,
  input  logic                  arb_grant,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_eop,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_reg,    state_next;
  logic [ADDR_WIDTH-1:0] dst_reg,      dst_next;
  logic [LEN_WIDTH-1:0]  remain_reg,   remain_next;
  logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [7:0]            drop_cnt_reg, drop_cnt_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic [DATA_WIDTH-1:0] tx_data_reg,  tx_data_next;
  logic                  tx_eop_reg,   tx_eop_next;

  hdr_t hdr;
  logic hdr_ok;
  logic pop_rdy;
  logic count_drop;
  logic rd_en;
  logic req;

  assign hdr     = parse_hdr(fifo_rdata);
  assign hdr_ok  = (hdr.len != '0) && (hdr.dst != '0);
  // Gating with rst_n keeps the FIFO and arbiter quiet while reset is held.
  assign pop_rdy = rst_n & ~fifo_empty;

  always_comb begin
    state_next    = state_reg;
    dst_next      = dst_reg;
    remain_next   = remain_reg;
    wait_cnt_next = wait_cnt_reg;
    drop_cnt_next = drop_cnt_reg;
    tx_valid_next = 1'b0;
    tx_data_next  = tx_data_reg;
    tx_eop_next   = 1'b0;
    rd_en         = 1'b0;
    req           = 1'b0;
    count_drop    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pop_rdy) begin
          rd_en = 1'b1;
          if (hdr_ok) begin
            state_next    = ST_XFER;
            dst_next      = hdr.dst;
            remain_next   = hdr.len;
            wait_cnt_next = '0;
          end else begin
            count_drop = 1'b1;
          end
        end
      end

      ST_XFER: begin
        req = pop_rdy;
        if (req && arb_grant) begin
          rd_en         = 1'b1;
          tx_valid_next = 1'b1;
          tx_data_next  = fifo_rdata;
          tx_eop_next   = (remain_reg == 4'd1);
          remain_next   = remain_reg - 4'd1;
          wait_cnt_next = '0;
          if (remain_reg == 4'd1) begin
            state_next = ST_IDLE;
          end
        end else if (req) begin
          // Starvation only counts while there is a beat to send.
          if (wait_cnt_reg == WAIT_LAST) begin
            state_next = ST_DROP;
            count_drop = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end
      end

      ST_DROP: begin
        rd_en = pop_rdy;
        if (pop_rdy) begin
          remain_next = remain_reg - 4'd1;
          if (remain_reg == 4'd1) begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (count_drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_next = drop_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      dst_reg      <= '0;
      remain_reg   <= '0;
      wait_cnt_reg <= '0;
      drop_cnt_reg <= '0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_eop_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dst_reg      <= dst_next;
      remain_reg   <= remain_next;
      wait_cnt_reg <= wait_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      tx_eop_reg   <= tx_eop_next;
    end
  end

  assign fifo_rd_en = rd_en;
  assign arb_req    = req;
  assign busy       = (state_reg != ST_IDLE);
  assign arb_dst    = busy ? dst_reg : '0;
  assign tx_valid   = tx_valid_reg;
  assign tx_data    = tx_data_reg;
  assign tx_eop     = tx_eop_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_port_ctrl.sv
// Randomized bench for port_ctrl: a queue-backed FWFT FIFO feeds the DUT and a
// packet-level reference model predicts every output on every cycle.
module tb_port_ctrl;
  import packet_pkg::*;

  localparam int TO = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  fifo_empty = 1'b1;
  logic [DATA_WIDTH-1:0] fifo_rdata = '0;
  logic                  fifo_rd_en;
  logic                  arb_req;
  logic [ADDR_WIDTH-1:0] arb_dst;
  logic                  arb_grant = 1'b0;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_eop;
  logic                  busy;
  logic [7:0]            drop_cnt;

  always #5 clk = ~clk;

  port_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .arb_req    (arb_req),
    .arb_dst    (arb_dst),
    .arb_grant  (arb_grant),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_eop     (tx_eop),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // environment
  logic [DATA_WIDTH-1:0] fifo_q[$];
  bit stall = 0;
  int grant_mode = 0;   // 0 never, 1 always, 2 alternate, 3 random
  int grant_pct = 50;
  bit alt_phase = 0;
  bit popped = 0;

  // reference model: words of the current packet still in the FIFO, and whether it is being discarded
  int m_left = 0;
  int m_wait = 0;
  int m_drop = 0;
  bit m_dropping = 0;
  logic [ADDR_WIDTH-1:0] m_dst = '0;
  bit e_tv = 0;
  bit e_te = 0;
  logic [DATA_WIDTH-1:0] e_td = '0;

  // observation for directed scenarios
  int cyc = 0;
  int beats = 0;
  int eops = 0;
  int eop_cyc = -1;
  int req_cycles = 0;
  int pops = 0;
  int tx_cycles[$];
  logic [DATA_WIDTH-1:0] tx_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] hd;
    int hl;
    bit e, g, exp_rd, exp_req;
    cyc++;
    if (!rst_n) begin
      chk("rst fifo_rd_en", fifo_rd_en, 0);
      chk("rst arb_req", arb_req, 0);
      chk("rst tx_valid", tx_valid, 0);
      chk("rst tx_eop", tx_eop, 0);
      chk("rst tx_data", tx_data, 0);
      chk("rst busy", busy, 0);
      chk("rst drop_cnt", drop_cnt, 0);
      m_left = 0; m_wait = 0; m_drop = 0; m_dropping = 0; m_dst = '0;
      e_tv = 0; e_te = 0; e_td = '0;
      popped = 0;
    end else begin
      chk("tx_valid", tx_valid, e_tv);
      chk("tx_eop", tx_eop, e_te);
      if (e_tv) chk("tx_data", tx_data, e_td);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("busy", busy, (m_left > 0));
      chk("arb_dst", arb_dst, (m_left > 0) ? m_dst : 0);

      if (tx_valid) begin
        beats++;
        tx_cycles.push_back(cyc);
        tx_log.push_back(tx_data);
        if (tx_eop) begin eops++; eop_cyc = cyc; end
      end
      if (arb_req) req_cycles++;

      e = fifo_empty;
      g = arb_grant;
      exp_rd = 0; exp_req = 0;
      e_tv = 0; e_te = 0;
      if (m_left == 0) begin
        exp_rd = !e;
        if (!e) begin
          hd = fifo_rdata[3:0];
          hl = int'(fifo_rdata[11:8]);
          if (hd == 0 || hl == 0) begin
            if (m_drop < 255) m_drop++;
          end else begin
            m_left = hl; m_dst = hd; m_wait = 0; m_dropping = 0;
          end
        end
      end else if (!m_dropping) begin
        exp_req = !e;
        if (exp_req && g) begin
          exp_rd = 1;
          e_tv = 1; e_td = fifo_rdata; e_te = (m_left == 1);
          m_left--; m_wait = 0;
        end else if (exp_req) begin
          if (m_wait == TO - 1) begin
            m_dropping = 1; m_wait = 0;
            if (m_drop < 255) m_drop++;
          end else begin
            m_wait++;
          end
        end
      end else begin
        exp_rd = !e;
        if (!e) begin
          m_left--;
          if (m_left == 0) m_dropping = 0;
        end
      end
      chk("fifo_rd_en", fifo_rd_en, exp_rd);
      chk("arb_req", arb_req, exp_req);
      popped = fifo_rd_en && !fifo_empty;
      if (popped) pops++;
    end
  end

  task automatic drive();
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    popped = 0;
    alt_phase = ~alt_phase;
    case (grant_mode)
      0: arb_grant = 1'b0;
      1: arb_grant = 1'b1;
      2: arb_grant = alt_phase;
      default: arb_grant = ($urandom_range(99) < grant_pct);
    endcase
    fifo_empty = stall || (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : DATA_WIDTH'($urandom);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic push_pkt(input logic [3:0] dst, input int len);
    logic [DATA_WIDTH-1:0] h;
    h = DATA_WIDTH'($urandom);
    h[3:0] = dst;
    h[11:8] = 4'(len);
    fifo_q.push_back(h);
    for (int i = 0; i < len; i++) fifo_q.push_back(DATA_WIDTH'($urandom));
    $display("pkt: dst=%b len=%0d queued=%0d", dst, len, fifo_q.size());
  endtask

  task automatic clear_obs();
    beats = 0; eops = 0; eop_cyc = -1; req_cycles = 0; pops = 0;
    tx_cycles.delete();
    tx_log.delete();
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    tick(1);
    while ((fifo_q.size() != 0 || busy) && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    if (fifo_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s drain: busy=%0b queued=%0d, required idle", tag, busy, fifo_q.size());
    end
    tick(2);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    tick(3);
    chk("init busy", busy, 0);
    chk("init drop_cnt", drop_cnt, 0);
    chk("init tx_valid", tx_valid, 0);
    rst_n = 1'b1;
    tick(2);

    // three beats back to back, one cycle after each grant
    clear_obs();
    grant_mode = 1;
    fifo_q.push_back(16'h0304);
    fifo_q.push_back(16'hA001);
    fifo_q.push_back(16'hA002);
    fifo_q.push_back(16'hA003);
    $display("pkt: dst=0100 len=3 fixed payload");
    wait_idle(50, "len3");
    chk("len3 beats", beats, 3);
    chk("len3 eops", eops, 1);
    if (beats == 3) begin
      chk("len3 beat1", tx_log[0], 16'hA001);
      chk("len3 beat3", tx_log[2], 16'hA003);
      chk("len3 consecutive", tx_cycles[2] - tx_cycles[0], 2);
      chk("len3 eop on third", eop_cyc, tx_cycles[2]);
    end

    // alternating grant spreads the beats two cycles apart
    clear_obs();
    grant_mode = 2;
    push_pkt(4'b0010, 2);
    wait_idle(50, "alt");
    chk("alt beats", beats, 2);
    if (beats == 2) chk("alt spacing", tx_cycles[1] - tx_cycles[0], 2);

    // dst=0 header is discarded alone
    clear_obs();
    grant_mode = 1;
    fifo_q.push_back(16'h0400);
    $display("pkt: dst=0000 len=4 header only");
    wait_idle(50, "dst0");
    chk("dst0 drop_cnt", drop_cnt, 1);
    chk("dst0 beats", beats, 0);
    chk("dst0 arb_req cycles", req_cycles, 0);

    // grant never: 8 requesting cycles then the packet drains
    clear_obs();
    grant_mode = 0;
    push_pkt(4'b0001, 5);
    wait_idle(100, "timeout");
    chk("timeout req cycles", req_cycles, TO);
    chk("timeout beats", beats, 0);
    chk("timeout pops", pops, 6);
    chk("timeout drop_cnt", drop_cnt, 2);

    // FIFO runs dry after beat 1; no timeout while empty
    clear_obs();
    grant_mode = 1;
    fifo_q.push_back(16'h0308);
    fifo_q.push_back(16'hB001);
    $display("pkt: dst=1000 len=3 split");
    tick(5);
    grant_mode = 0;
    req_cycles = 0;
    tick(10);
    chk("starve arb_req cycles", req_cycles, 0);
    chk("starve busy", busy, 1);
    grant_mode = 1;
    fifo_q.push_back(16'hB002);
    fifo_q.push_back(16'hB003);
    wait_idle(50, "starve");
    chk("starve beats", beats, 3);
    chk("starve eops", eops, 1);
    chk("starve drop_cnt", drop_cnt, 2);

    // reset in the middle of a transfer
    clear_obs();
    grant_mode = 1;
    push_pkt(4'b0100, 6);
    tick(3);
    rst_n = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    #1;
    chk("midrst tx_valid", tx_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst arb_req", arb_req, 0);
    chk("midrst drop_cnt", drop_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("postrst busy", busy, 0);
    chk("postrst drop_cnt", drop_cnt, 0);

    // saturation of the drop counter
    grant_mode = 1;
    for (int i = 0; i < 270; i++) fifo_q.push_back(16'h0000);
    $display("pkt: 270 empty headers");
    wait_idle(600, "sat");
    chk("sat drop_cnt", drop_cnt, 255);
    pulse_reset();

    // randomized traffic
    for (int p = 0; p < 160; p++) begin
      if (fifo_q.size() < 40)
        push_pkt(($urandom_range(9) == 0) ? 4'h0 : 4'($urandom_range(15, 1)), $urandom_range(15));
      grant_mode = 3;
      case ($urandom_range(3))
        0: grant_pct = 0;
        1: grant_pct = 30;
        2: grant_pct = 70;
        default: grant_pct = 100;
      endcase
      stall = ($urandom_range(4) == 0);
      tick($urandom_range(20, 1));
    end
    stall = 0;
    grant_mode = 1;
    wait_idle(3000, "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, required completion");
    $fatal(1, "watchdog");
  end

endmodule
